nibble_mul_sequencer: RTL

- Computes a W x W unsigned product by time-multiplexing one shared 4x4 unsigned multiply unit over (W/4)^2 cycles.
- Each cycle the unit's full 8-bit result is shifted and added into a 2W-bit accumulator.
- Sits between a valid/ready operand source and a valid/ready result sink, e.g. a tile's ui_in/uo_out glue.
- Trades throughput for area versus a full-width array multiplier.

---
 rtl/nibble_mul_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/nibble_mul_sequencer.sv
// W x W unsigned multiplier that reuses one 4x4 multiply unit over (W/4)^2 cycles.
// Optional macro NIBBLE_MUL_EARLY_ZERO_EN: a zero operand goes straight to DONE.

module nibble_mul4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] p
);
  assign p = 8'(x) * 8'(y);
endmodule

module nibble_mul_sequencer #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);
  localparam int N  = W / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [IW-1:0]     nib_i_q, nib_i_d, nib_j_q, nib_j_d;
  logic [N-1:0][3:0] a_nib, b_nib;
  logic [7:0]        nib_prod;
  logic [IW:0]       nib_sum;
  logic [PW-1:0]     term;
  logic              last_i, last_step;

  assign a_nib = a_q;
  assign b_nib = b_q;

  // The one shared multiply unit; the step counters pick which nibble pair it sees.
  nibble_mul4 u_mul (
    .x(a_nib[nib_i_q]),
    .y(b_nib[nib_j_q]),
    .p(nib_prod)
  );

  assign nib_sum   = {1'b0, nib_i_q} + {1'b0, nib_j_q};
  assign term      = PW'(nib_prod) << {nib_sum, 2'b00};
  assign last_i    = (nib_i_q == IW'(N - 1));
  assign last_step = last_i && (nib_j_q == IW'(N - 1));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    nib_i_d = nib_i_q;
    nib_j_d = nib_j_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          nib_i_d = '0;
          nib_j_d = '0;
          state_d = S_CALC;
`ifdef NIBBLE_MUL_EARLY_ZERO_EN
          if (a == '0 || b == '0) state_d = S_DONE;
`endif
        end
      end
      S_CALC: begin
        acc_d = acc_q + term;
        if (last_step) begin
          nib_i_d = '0;
          nib_j_d = '0;
          state_d = S_DONE;
        end else if (last_i) begin
          nib_i_d = '0;
          nib_j_d = nib_j_q + 1'b1;
        end else begin
          nib_i_d = nib_i_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      nib_i_q <= '0;
      nib_j_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      nib_i_q <= nib_i_d;
      nib_j_q <= nib_j_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign product   = acc_q;

endmodule
